// File: rtl/landscape_hist_rmw_if.sv
// Bundle of the sample handshake, increment-stage, RAM and sweep-control
// signals of the histogram read-modify-write controller.
interface landscape_hist_rmw_if #(
    parameter int bit_addr     = 10,
    parameter int bit_addr_acc = 19
);
    // Sample handshake
    logic                    in_valid;
    logic                    in_ready;
    logic [bit_addr-1:0]     in_addr;

    // Increment stage
    logic [bit_addr_acc-1:0] acc_old;
    logic                    valid_de1;
    logic [bit_addr_acc-1:0] acc_new;

    // Histogram RAM
    logic [bit_addr-1:0]     ram_raddr;
    logic [bit_addr_acc-1:0] ram_rdata;
    logic [bit_addr-1:0]     ram_waddr;
    logic [bit_addr_acc-1:0] ram_wdata;
    logic                    ram_we;

    // Sweep control and status
    logic                    sweep_start;
    logic                    busy;
    logic                    sweep_done;
    logic [31:0]             sample_cnt;

    // Environment side: sample source, increment stage and RAM
    modport master (
        output in_valid, in_addr, acc_new, ram_rdata, sweep_start,
        input  in_ready, acc_old, valid_de1, ram_raddr, ram_waddr,
               ram_wdata, ram_we, busy, sweep_done, sample_cnt
    );

    // Controller side
    modport slave (
        input  in_valid, in_addr, acc_new, ram_rdata, sweep_start,
        output in_ready, acc_old, valid_de1, ram_raddr, ram_waddr,
               ram_wdata, ram_we, busy, sweep_done, sample_cnt
    );
endinterface

// File: rtl/landscape_hist_rmw.sv
// Read-modify-write controller for the LandscapeSampling histogram.
// Issues the RAM read for each accepted bin, hands the current count to the
// increment stage at DE1 (forwarding in-flight values for repeated bins) and
// writes the incremented count back at DE2. A sweep mode zeroes every bin
// after draining the pipeline.
module landscape_hist_rmw #(
    parameter int bit_addr     = 10,
    parameter int bit_addr_acc = 19
) (
    input  logic                 clk,
    input  logic                 clr,
    landscape_hist_rmw_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Sweep counter is one bit wider so the terminal compare never wraps
    localparam logic [bit_addr:0] SC_LAST = {1'b0, {bit_addr{1'b1}}};

    state_t                  state;
    state_t                  state_nxt;

    logic                    in_ready_c;
    logic                    busy_c;
    logic                    sweep_done_c;
    logic                    sweep_run;
    logic                    accept;

    logic [bit_addr-1:0]     raddr_hold;
    logic [bit_addr-1:0]     raddr_c;

    logic                    vld_p1;
    logic [bit_addr-1:0]     addr_p1;
    logic                    vld_p2;
    logic [bit_addr-1:0]     addr_p2;

    logic                    wq_v;
    logic [bit_addr-1:0]     wq_a;
    logic [bit_addr_acc-1:0] wq_data;

    logic                    we_c;
    logic [bit_addr-1:0]     waddr_c;
    logic [bit_addr_acc-1:0] wdata_c;
    logic [bit_addr_acc-1:0] acc_old_c;

    logic [bit_addr:0]       sc;
    logic [31:0]             sample_cnt_q;

    // Newest in-flight value wins: DE2 result, then last cycle's write, then RAM
    function automatic logic [bit_addr_acc-1:0] fwd_select(
        input logic                    de2_hit,
        input logic [bit_addr_acc-1:0] de2_val,
        input logic                    wq_hit,
        input logic [bit_addr_acc-1:0] wq_val,
        input logic [bit_addr_acc-1:0] ram_val
    );
        if (de2_hit)
            return de2_val;
        else if (wq_hit)
            return wq_val;
        else
            return ram_val;
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and mode outputs; a sweep_start cycle never accepts a sample
    always_comb begin
        state_nxt    = state;
        in_ready_c   = 1'b0;
        busy_c       = 1'b0;
        sweep_done_c = 1'b0;
        sweep_run    = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = ~bus.sweep_start;
                if (bus.sweep_start)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (!vld_p1 && !vld_p2)
                    state_nxt = SWEEP;
            end
            SWEEP: begin
                busy_c    = 1'b1;
                sweep_run = 1'b1;
                if (sc == SC_LAST) begin
                    sweep_done_c = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- S0: accept the sample and issue the RAM read ----
    always_comb begin
        accept  = bus.in_valid & in_ready_c;
        raddr_c = accept ? bus.in_addr : raddr_hold;
    end

    // Read address holds its last value while nothing is accepted
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            raddr_hold <= '0;
        else
            raddr_hold <= raddr_c;
    end

    // ---- DE1 / DE2: pipeline valid and bin address ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            vld_p2  <= 1'b0;
            addr_p2 <= '0;
        end else begin
            vld_p1  <= accept;
            if (accept)
                addr_p1 <= bus.in_addr;
            vld_p2  <= vld_p1;
            addr_p2 <= addr_p1;
        end
    end

    // DE1 forwarding mux covering the RAM's old-data read-during-write behaviour
    always_comb begin
        acc_old_c = fwd_select(vld_p2 && (addr_p2 == addr_p1), bus.acc_new,
                               wq_v && (wq_a == addr_p1), wq_data,
                               bus.ram_rdata);
    end

    // ---- DE2: write port, shared between sample writes and the zero sweep ----
    always_comb begin
        we_c    = vld_p2 | sweep_run;
        waddr_c = sweep_run ? sc[bit_addr-1:0] : addr_p2;
        wdata_c = sweep_run ? '0 : bus.acc_new;
    end

    // Write queue: last cycle's write, for the read that missed it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wq_v    <= 1'b0;
            wq_a    <= '0;
            wq_data <= '0;
        end else begin
            wq_v    <= we_c & ~sweep_done_c;
            wq_a    <= waddr_c;
            wq_data <= wdata_c;
        end
    end

    // Sweep counter walks every bin once, then rearms at zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            sc <= '0;
        else if (sweep_done_c)
            sc <= '0;
        else if (sweep_run)
            sc <= sc + 1'b1;
    end

    // Accepted-sample counter, cleared when the histogram is cleared
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            sample_cnt_q <= '0;
        else if (sweep_done_c)
            sample_cnt_q <= '0;
        else if (accept)
            sample_cnt_q <= sample_cnt_q + 32'd1;
    end

    // Drive the interface outputs
    always_comb begin
        bus.in_ready   = in_ready_c;
        bus.ram_raddr  = raddr_c;
        bus.valid_de1  = vld_p1;
        bus.acc_old    = acc_old_c;
        bus.ram_we     = we_c;
        bus.ram_waddr  = waddr_c;
        bus.ram_wdata  = wdata_c;
        bus.busy       = busy_c;
        bus.sweep_done = sweep_done_c;
        bus.sample_cnt = sample_cnt_q;
    end

endmodule

// File: tb/tb_landscape_hist_rmw.sv
// Bench for landscape_hist_rmw: behavioural RAM and increment stage around
// the controller, with a per-bin count model that predicts every write.
module tb_landscape_hist_rmw;

    localparam int BA    = 4;
    localparam int BW    = 19;
    localparam int DEPTH = 1 << BA;

    typedef struct {
        int          due;
        logic [BA-1:0] a;
        logic [BW-1:0] old;
        logic [BW-1:0] nw;
    } wr_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    landscape_hist_rmw_if #(.bit_addr(BA), .bit_addr_acc(BW)) bus ();

    landscape_hist_rmw #(.bit_addr(BA), .bit_addr_acc(BW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [BW-1:0] mem      [DEPTH];
    logic [BW-1:0] exp_hist [DEPTH];
    wr_t           q [$];
    int            exp_cnt     = 0;
    int            sweep_exp   = 0;
    logic          sweep_armed = 1'b0;

    logic          ld_en = 1'b0;
    logic [BA-1:0] ld_a  = '0;
    logic [BW-1:0] ld_d  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM with 1-cycle read, old data on read-during-write; registered +1 stage
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_raddr];
        if (bus.ram_we)
            mem[bus.ram_waddr] <= bus.ram_wdata;
        else if (ld_en)
            mem[ld_a] <= ld_d;
        bus.acc_new <= bus.acc_old + 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: checks writes and DE1 values by due cycle, records accepts
    always @(negedge clk) begin
        if (!clr) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("wr_we",    64'(bus.ram_we), 64'(1));
                chk("wr_addr",  64'(bus.ram_waddr), 64'(q[0].a));
                chk("wr_data",  64'(bus.ram_wdata), 64'(q[0].nw));
                chk("wr_done",  64'(bus.sweep_done), 64'(0));
                void'(q.pop_front());
            end else if (bus.ram_we) begin
                if (!sweep_armed) begin
                    chk("unexpected_we", 64'(bus.ram_we), 64'(0));
                end else begin
                    chk("sweep_addr", 64'(bus.ram_waddr), 64'(sweep_exp));
                    chk("sweep_data", 64'(bus.ram_wdata), 64'(0));
                    chk("sweep_done", 64'(bus.sweep_done), 64'(sweep_exp == DEPTH - 1));
                    sweep_exp++;
                end
            end else begin
                chk("done_idle", 64'(bus.sweep_done), 64'(0));
            end

            if (q.size() > 0 && q[0].due == cyc + 1) begin
                chk("de1_valid", 64'(bus.valid_de1), 64'(1));
                chk("acc_old",   64'(bus.acc_old), 64'(q[0].old));
            end else begin
                chk("de1_idle", 64'(bus.valid_de1), 64'(0));
            end

            if (bus.in_valid && bus.in_ready) begin
                wr_t e;
                e.due = cyc + 2;
                e.a   = bus.in_addr;
                e.old = exp_hist[bus.in_addr];
                e.nw  = exp_hist[bus.in_addr] + 1'b1;
                exp_hist[bus.in_addr] = e.nw;
                q.push_back(e);
                exp_cnt++;
            end
        end
    end

    task automatic step(input logic v, input logic [BA-1:0] a);
        bus.in_valid = v;
        bus.in_addr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic poke(input logic [BA-1:0] a, input logic [BW-1:0] d);
        ld_a  = a;
        ld_d  = d;
        ld_en = 1'b1;
        exp_hist[a] = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, BA'($urandom_range(0, DEPTH - 1)));
        idle(4);
        chk("pending_writes", 64'(q.size()), 64'(0));
        chk("sample_cnt",     64'(bus.sample_cnt), 64'(exp_cnt));
    endtask

    // Waits for the sweep to finish, then checks the post-sweep state
    task automatic finish_sweep();
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.sweep_done === 1'b1) begin
                seen = 1'b1;
                chk("ready_in_done", 64'(bus.in_ready), 64'(0));
            end
        end
        chk("sweep_done_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        sweep_armed = 1'b0;
        chk("sweep_writes",  64'(sweep_exp), 64'(DEPTH));
        chk("post_busy",     64'(bus.busy), 64'(0));
        chk("post_ready",    64'(bus.in_ready), 64'(1));
        chk("post_cnt",      64'(bus.sample_cnt), 64'(0));
        exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) exp_hist[i] = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_addr     = '0;
        bus.sweep_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",   64'(bus.in_ready), 64'(1));
        chk("rst_valid_de1",  64'(bus.valid_de1), 64'(0));
        chk("rst_ram_we",     64'(bus.ram_we), 64'(0));
        chk("rst_busy",       64'(bus.busy), 64'(0));
        chk("rst_sweep_done", 64'(bus.sweep_done), 64'(0));
        chk("rst_sample_cnt", 64'(bus.sample_cnt), 64'(0));
        clr = 1'b0;

        for (int i = 0; i < DEPTH; i++) poke(BA'(i), BW'($urandom_range(0, 5000)));

        // Single sample, bin 5 holding 7
        poke(4'd5, 19'd7);
        step(1'b1, 4'd5);
        idle(4);

        // Four back-to-back hits on bin 3
        poke(4'd3, 19'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd3);
        idle(4);
        chk("bin3_final", 64'(exp_hist[3]), 64'(4));

        // A, B, A with A holding 10
        poke(4'd9, 19'd10);
        step(1'b1, 4'd9);
        step(1'b1, 4'd2);
        step(1'b1, 4'd9);
        idle(4);

        // Count wrap at full scale
        poke(4'd12, {BW{1'b1}});
        step(1'b1, 4'd12);
        idle(4);
        chk("sample_cnt_dir", 64'(bus.sample_cnt), 64'(9));

        rand_run(300);

        // Sweep requested with two samples in flight; a late request is ignored
        sweep_exp   = 0;
        sweep_armed = 1'b1;
        step(1'b1, 4'd7);
        step(1'b1, 4'd8);
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_addr     = 4'd1;
        #1;
        chk("ready_at_start", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b0;
        chk("busy_drain", 64'(bus.busy), 64'(1));
        idle(4);
        bus.sweep_start = 1'b1;
        step(1'b1, 4'd4);
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b0;
        finish_sweep();

        rand_run(150);

        // Reset mid-sweep
        sweep_exp   = 0;
        sweep_armed = 1'b1;
        bus.sweep_start = 1'b1;
        step(1'b0, '0);
        bus.sweep_start = 1'b0;
        idle(6);
        sweep_armed = 1'b0;
        clr = 1'b1;
        #1;
        chk("clr_ram_we",     64'(bus.ram_we), 64'(0));
        chk("clr_busy",       64'(bus.busy), 64'(0));
        chk("clr_sample_cnt", 64'(bus.sample_cnt), 64'(0));
        chk("clr_in_ready",   64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        clr     = 1'b0;
        exp_cnt = 0;

        // Bins are undefined after reset: sweep, then use the cleared histogram
        sweep_exp   = 0;
        sweep_armed = 1'b1;
        bus.sweep_start = 1'b1;
        step(1'b0, '0);
        bus.sweep_start = 1'b0;
        finish_sweep();
        rand_run(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
